// File: rtl/uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// uart_cmd_rx
// UART 8N1 receiver with an ASCII command decoder. Each received character
// becomes a one-cycle control pulse that means the same as a front-panel
// button press: BPM +1, +5, -1, -5 and reset. The raw byte, a valid strobe
// and a framing-error strobe are also brought out for diagnostics.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_uart_rx      raw serial input; asynchronous; idles high
//   o_rx_data      last correctly framed byte; holds until the next one
//   o_rx_valid     one-cycle pulse when o_rx_data updates
//   o_frame_err    one-cycle pulse when the stop bit is sampled low
//   o_cmd_plus_1   pulse for '+'
//   o_cmd_plus_5   pulse for 'U' / 'u'
//   o_cmd_minus_1  pulse for '-'
//   o_cmd_minus_5  pulse for 'D' / 'd'
//   o_cmd_reset    pulse for 'R' / 'r'
// ---------------------------------------------------------------------------
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_cmd_plus_1,
  output logic       o_cmd_plus_5,
  output logic       o_cmd_minus_1,
  output logic       o_cmd_minus_5,
  output logic       o_cmd_reset
);

  // The start bit is checked half a bit after its falling edge; every later
  // sample is a full bit period after the previous one, i.e. at mid-bit.
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;

  logic rx_s1_q, rx_s2_q, rx_prev_q;
  logic byte_done, frame_bad;

  logic [7:0] rx_data_q;
  logic       rx_valid_q, frame_err_q;
  logic       plus_1_q, plus_5_q, minus_1_q, minus_5_q, reset_cmd_q;

  // Synchronizer and edge-detect flops preset high (line idle level) so that
  // leaving reset never looks like a start-bit falling edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its neighbour, which is what gives a real two-stage synchronizer.
      rx_s1_q   <= i_uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_bad = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == HALF_BIT) begin
          if (!rx_s2_q) begin
            state_d   = S_DATA;
            clk_cnt_d = '0;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;   // too short to be a start bit
          end
        end
      end
      S_DATA: begin
        if (clk_cnt_q == FULL_BIT) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s2_q;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        if (clk_cnt_q == FULL_BIT) begin
          clk_cnt_d = '0;
          if (rx_s2_q) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Held-low line: stay here so a break yields a single error pulse.
        clk_cnt_d = '0;
        if (rx_s2_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output strobes are registered, so they appear the cycle after the
  // stop-bit sample, together with the new o_rx_data.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      plus_1_q    <= 1'b0;
      plus_5_q    <= 1'b0;
      minus_1_q   <= 1'b0;
      minus_5_q   <= 1'b0;
      reset_cmd_q <= 1'b0;
    end else begin
      rx_valid_q  <= byte_done;
      frame_err_q <= frame_bad;
      if (byte_done) rx_data_q <= shift_q;
      // Command set is disjoint, so at most one of these can be high.
      plus_1_q    <= byte_done && (shift_q == 8'h2B);
      plus_5_q    <= byte_done && (shift_q == 8'h55 || shift_q == 8'h75);
      minus_1_q   <= byte_done && (shift_q == 8'h2D);
      minus_5_q   <= byte_done && (shift_q == 8'h44 || shift_q == 8'h64);
      reset_cmd_q <= byte_done && (shift_q == 8'h52 || shift_q == 8'h72);
    end
  end

  assign o_rx_data     = rx_data_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_frame_err   = frame_err_q;
  assign o_cmd_plus_1  = plus_1_q;
  assign o_cmd_plus_5  = plus_5_q;
  assign o_cmd_minus_1 = minus_1_q;
  assign o_cmd_minus_5 = minus_5_q;
  assign o_cmd_reset   = reset_cmd_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_rx
// Bench for uart_cmd_rx at CLKS_PER_BIT=16 with a 10 ns clock. Each
// transmitted good byte pushes its expected data and command vector onto a
// scoreboard queue; a monitor pops and compares on every o_rx_valid pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_cmd_rx;

  localparam int  CPB    = 16;
  localparam real CLK_NS = 10.0;
  localparam real BIT_NS = CPB * CLK_NS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err;
  logic       plus_1, plus_5, minus_1, minus_5, cmd_reset;

  // Command vector order: {plus_1, plus_5, minus_1, minus_5, reset}
  typedef struct {
    logic [7:0] data;
    logic [4:0] cmd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   valid_cnt = 0;
  int   ferr_cnt = 0;
  time  last_valid_t = 0;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_uart_rx    (rx),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_frame_err  (frame_err),
    .o_cmd_plus_1 (plus_1),
    .o_cmd_plus_5 (plus_5),
    .o_cmd_minus_1(minus_1),
    .o_cmd_minus_5(minus_5),
    .o_cmd_reset  (cmd_reset)
  );

  always #(CLK_NS / 2) clk = ~clk;

  function automatic logic [4:0] model_cmd(input logic [7:0] c);
    case (c)
      8'h2B:        return 5'b10000;
      8'h55, 8'h75: return 5'b01000;
      8'h2D:        return 5'b00100;
      8'h44, 8'h64: return 5'b00010;
      8'h52, 8'h72: return 5'b00001;
      default:      return 5'b00000;
    endcase
  endfunction

  function automatic exp_t mk_exp(input logic [7:0] c);
    exp_t e;
    e.data = c;
    e.cmd  = model_cmd(c);
    return e;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [4:0] cmd_v;
    exp_t       e;
    cmd_v = {plus_1, plus_5, minus_1, minus_5, cmd_reset};
    if (frame_err) ferr_cnt++;
    if (rx_valid) begin
      valid_cnt++;
      last_valid_t = $time;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: data=%h cmd=%b, required no valid pulse", rx_data, cmd_v);
      end else begin
        e = sb.pop_front();
        if (rx_data !== e.data || cmd_v !== e.cmd) begin
          bad++;
          $display("FAIL scoreboard: data=%h cmd=%b, required data=%h cmd=%b",
                   rx_data, cmd_v, e.data, e.cmd);
        end
      end
    end else if (cmd_v !== 5'b00000) begin
      total++;
      bad++;
      $display("FAIL cmd_without_valid: cmd=%b, required 00000", cmd_v);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input real bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_bit;
    #(bit_ns);
  endtask

  task automatic send_good(input logic [7:0] b, input real bit_ns);
    sb.push_back(mk_exp(b));
    send_byte(b, 1'b1, bit_ns);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 4 * CPB * 10) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: %0d bytes outstanding, required 0", name, sb.size());
      sb.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({rx_data, rx_valid, frame_err, plus_1, plus_5, minus_1, minus_5, cmd_reset} !== 15'h0) begin
      bad++;
      $display("FAIL reset_outputs: data=%h valid=%b ferr=%b cmd=%b, required all 0",
               rx_data, rx_valid, frame_err, {plus_1, plus_5, minus_1, minus_5, cmd_reset});
    end
    rst_n = 1'b1;
    repeat (5 * CPB) @(posedge clk);
    #1;
    total++;
    if (valid_cnt != 0 || ferr_cnt != 0) begin
      bad++;
      $display("FAIL reset_release_quiet: valid=%0d ferr=%0d, required 0 0", valid_cnt, ferr_cnt);
    end
  endtask

  task automatic test_plus();
    int  v0 = valid_cnt;
    time t0;
    longint lat;
    @(posedge clk);
    #1;
    t0 = $time;
    send_good(8'h2B, BIT_NS);
    wait_drain("plus");
    total++;
    if (valid_cnt - v0 != 1 || rx_data !== 8'h2B) begin
      bad++;
      $display("FAIL plus_single: valids=%0d data=%h, required 1 2b", valid_cnt - v0, rx_data);
    end
    // 2 sync cycles + 9.5 bits + 1 = 155 cycles, allow a cycle or two of slop.
    lat = (last_valid_t - t0) / 10;
    total++;
    if (lat < 153 || lat > 157) begin
      bad++;
      $display("FAIL plus_latency: %0d cycles, required about 155", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg [7];
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    msg = '{8'h55, 8'h75, 8'h64, 8'h44, 8'h2D, 8'h72, 8'h52};
    foreach (msg[i]) send_good(msg[i], BIT_NS);
    wait_drain("b2b");
    total++;
    if (valid_cnt - v0 != 7 || ferr_cnt != f0) begin
      bad++;
      $display("FAIL b2b_counts: valids=%0d ferr=%0d, required 7 0", valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_non_cmd();
    send_good(8'h41, BIT_NS);
    wait_drain("non_cmd");
    total++;
    if (rx_data !== 8'h41) begin
      bad++;
      $display("FAIL non_cmd_data: %h, required 41", rx_data);
    end
  endtask

  task automatic test_frame_err();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    send_byte(8'h2B, 1'b0, BIT_NS);
    #(40 * BIT_NS);
    rx = 1'b1;
    #(2 * BIT_NS);
    total++;
    if (ferr_cnt - f0 != 1) begin
      bad++;
      $display("FAIL frame_err_count: %0d, required 1", ferr_cnt - f0);
    end
    total++;
    if (valid_cnt != v0 || rx_data !== 8'h41) begin
      bad++;
      $display("FAIL frame_err_quiet: valids=%0d data=%h, required 0 41", valid_cnt - v0, rx_data);
    end
    send_good(8'h2D, BIT_NS);
    wait_drain("after_break");
    total++;
    if (ferr_cnt - f0 != 1 || valid_cnt - v0 != 1) begin
      bad++;
      $display("FAIL after_break_counts: ferr=%0d valids=%0d, required 1 1",
               ferr_cnt - f0, valid_cnt - v0);
    end
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    #(20 * BIT_NS);
    total++;
    if (valid_cnt != v0 || ferr_cnt != f0) begin
      bad++;
      $display("FAIL glitch_quiet: valids=%0d ferr=%0d, required 0 0", valid_cnt - v0, ferr_cnt - f0);
    end
    send_good(8'h2B, BIT_NS);
    wait_drain("after_glitch");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b = 8'h2B;
    int v0, f0;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = b[4];
    #(BIT_NS / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    v0    = valid_cnt;
    f0    = ferr_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #(20 * BIT_NS);
    total++;
    if (valid_cnt != v0 || ferr_cnt != f0 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_mid_frame: valids=%0d ferr=%0d data=%h, required 0 0 00",
               valid_cnt - v0, ferr_cnt - f0, rx_data);
    end
  endtask

  task automatic test_tolerance();
    send_good(8'h64, BIT_NS * 1.03125);   // 16.5 clocks per bit
    wait_drain("fast_tol");
    total++;
    if (rx_data !== 8'h64) begin
      bad++;
      $display("FAIL tolerance_data: %h, required 64", rx_data);
    end
  endtask

  initial begin
    test_reset();
    test_plus();
    test_back_to_back();
    test_non_cmd();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    test_tolerance();
    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
UART 8N1 receiver and ASCII command decoder driven from the i_uart_rx pin. It converts received characters into single-cycle control pulses with the same meaning as the front-panel buttons: BPM +1, +5, -1, -5 and reset. It sits directly upstream of the metronome and is OR-ed with the btn_debouncer outputs at top level. Raw byte, valid and framing-error outputs are also provided for diagnostics.

Parameters:
CLKS_PER_BIT, 434, i_clk cycles per UART bit (50 MHz / 115200); legal range is 4 or more.
CNT_W, 16, width of the bit-timing counter; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
i_clk  in  1  system clock (pll_clk domain)
i_reset_n  in  1  asynchronous active-low reset
i_uart_rx  in  1  raw serial input; asynchronous; idle level high
o_rx_data  out  8  last correctly framed byte; holds until the next valid byte
o_rx_valid  out  1  one-cycle pulse when o_rx_data updates
o_frame_err  out  1  one-cycle pulse when the stop bit is sampled low
o_cmd_plus_1  out  1  one-cycle pulse for '+'
o_cmd_plus_5  out  1  one-cycle pulse for 'U' or 'u'
o_cmd_minus_1  out  1  one-cycle pulse for '-'
o_cmd_minus_5  out  1  one-cycle pulse for 'D' or 'd'
o_cmd_reset  out  1  one-cycle pulse for 'R' or 'r'

Behaviour:
- Reset (i_reset_n=0, asynchronous):
  - All outputs go to 0 and o_rx_data to 8'h00.
  - FSM goes to IDLE; counters clear.
  - Both synchronizer flops preset to 1, so no false start bit is seen after reset.
- Input path: 2-flop synchronizer, then a registered copy for edge detection. Total input latency is 2 cycles.
- IDLE: a falling edge on the synchronized rx moves the FSM to START and clears clk_cnt.
- START:
  - At clk_cnt == (CLKS_PER_BIT-1)/2, sample rx.
  - rx=0: go to DATA, clear clk_cnt and bit_idx.
  - rx=1: glitch; return to IDLE with no output.
- DATA:
  - Sample rx when clk_cnt == CLKS_PER_BIT-1, i.e. at mid-bit.
  - Shift into bit position bit_idx, LSB first.
  - After bit_idx=7, go to STOP.
- STOP: sample at mid-bit.
  - rx=1: on the next cycle, load o_rx_data, pulse o_rx_valid, pulse the matching o_cmd_* output, then go to IDLE.
  - rx=0: on the next cycle, pulse o_frame_err only, with no cmd or valid pulse and o_rx_data unchanged. Then go to BREAK.
- BREAK: wait until the synchronized rx is 1, then go to IDLE. A held-low line (break condition) therefore produces exactly one o_frame_err.
- Command decoding:
  - Any byte outside the command set still produces o_rx_valid but no cmd pulse.
  - At most one o_cmd_* output is high in any cycle.
  - Cmd pulses are coincident with o_rx_valid.
- Back-to-back frames: a start bit that begins immediately after the stop-bit mid-sample is accepted. The FSM reaches IDLE by mid-stop plus 1 cycle.
- Latency: the cmd pulse occurs 2 sync cycles plus 9.5 bit times plus 1 cycle after the start-bit falling edge at the pin.
- Reset mid-frame discards the partial byte; no pulse is emitted after reset is released.
- Tolerance: clock mismatch up to ±3% must decode correctly because sampling is at mid-bit.

Test Plan:
- CLKS_PER_BIT=16. Send 8'h2B ('+') at exact rate -> one o_cmd_plus_1 pulse and o_rx_valid coincident, o_rx_data=8'h2B, no other cmd pulse.
- Send "UudD-rR" back-to-back with no idle gap -> pulse sequence plus_5, plus_5, minus_5, minus_5, minus_1, reset, reset, 7 o_rx_valid pulses, o_frame_err never asserted.
- Send 8'h41 ('A') -> o_rx_valid=1 and o_rx_data=8'h41; all o_cmd_* stay 0.
- Send 8'h2B with the stop bit forced low, then hold the line low for 40 bit times, then release and send '-' -> exactly one o_frame_err, no plus_1, o_rx_data unchanged, then one minus_1.
- Apply a 5-cycle low glitch on idle rx -> no valid, cmd or frame_err pulse; a following '+' decodes normally.
- Assert i_reset_n=0 during bit 4 of '+', release, then idle -> no pulses and o_rx_data=8'h00. Next, send 'd' at a bit period of 16.5 cycles (+3%) -> o_cmd_minus_5 pulses.
